// File: rtl/gsim_pkg.sv
// Shared encodings for the GSIM Gauss-Seidel sequencing controller.
// Pure declarations; no logic, no latency, no flow control.
package gsim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  localparam logic [1:0] SHREG_HOLD   = 2'b00;
  localparam logic [1:0] SHREG_SHIFT1 = 2'b01;
  localparam logic [1:0] SHREG_SHIFT4 = 2'b10;
  localparam logic [1:0] SHREG_SHIFT5 = 2'b11;

  localparam logic [1:0] X_SEL_ZERO   = 2'b00;
  localparam logic [1:0] X_SEL_PE     = 2'b01;
  localparam logic [1:0] X_SEL_RECIRC = 2'b10;

  localparam logic B_SEL_IN     = 1'b0;
  localparam logic B_SEL_RECIRC = 1'b1;

  localparam int GSIM_N = 16;

endpackage

// File: rtl/gsim_nbr_mask.sv
// Row index to 6-neighbour boundary mask; purely combinational, zero latency.
// A bit is set only when that neighbour row lies inside 0..N-1.
module gsim_nbr_mask #(
  parameter int N = 16
) (
  input  logic [$clog2(N)-1:0] row_idx,
  output logic [5:0]           pe_mask
);

  localparam int RW = $clog2(N);

  // Even bits look down (r+k), odd bits look up (r-k), k = 1..3.
  always_comb begin
    pe_mask[0] = (row_idx <= RW'(N - 2));
    pe_mask[1] = (row_idx >= RW'(1));
    pe_mask[2] = (row_idx <= RW'(N - 3));
    pe_mask[3] = (row_idx >= RW'(2));
    pe_mask[4] = (row_idx <= RW'(N - 4));
    pe_mask[5] = (row_idx >= RW'(3));
  end

endmodule

// File: rtl/gsim_seq_ctrl.sv
// Load/Calc/Out sequencer for the GSIM datapath: one row every PE_LAT+1 cycles.
// Words are taken only while in_ready (IDLE/LOAD); in_en elsewhere is ignored.
module gsim_seq_ctrl
  import gsim_pkg::*;
#(
  parameter int N       = GSIM_N,
  parameter int NR_ITER = 10,
  parameter int PE_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_en,
  output logic                 in_ready,
  output logic                 b_shreg_en,
  output logic [1:0]           b_shreg_ctrl,
  output logic                 b_sel,
  output logic                 x_shreg_en,
  output logic [1:0]           x_shreg_ctrl,
  output logic [1:0]           x_sel,
  output logic                 pe_issue,
  output logic [5:0]           pe_mask,
  output logic [$clog2(N)-1:0] row_idx,
  output logic [3:0]           iter_idx,
  output logic                 out_valid,
  output logic                 done
);

  localparam int RW = $clog2(N);
  localparam int WW = (PE_LAT > 2) ? $clog2(PE_LAT - 1) : 1;

  localparam logic [RW-1:0] ROW_LAST  = RW'(N - 1);
  localparam logic [3:0]    ITER_LAST = 4'(NR_ITER - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'((PE_LAT >= 2) ? PE_LAT - 2 : 0);

  state_t        state_q, state_d;
  logic [RW-1:0] load_q, load_d;
  logic [RW-1:0] row_q, row_d;
  logic [3:0]    iter_q, iter_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [5:0]    mask_raw;

  gsim_nbr_mask #(.N(N)) u_nbr_mask (
    .row_idx (row_q),
    .pe_mask (mask_raw)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      load_q  <= '0;
      row_q   <= '0;
      iter_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      row_q   <= row_d;
      iter_q  <= iter_d;
      wait_q  <= wait_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign row_idx  = row_q;
  assign iter_idx = iter_q;

  always_comb begin
    state_d      = state_q;
    load_d       = load_q;
    row_d        = row_q;
    iter_d       = iter_q;
    wait_d       = wait_q;
    b_shreg_en   = 1'b0;
    b_shreg_ctrl = SHREG_HOLD;
    b_sel        = B_SEL_IN;
    x_shreg_en   = 1'b0;
    x_shreg_ctrl = SHREG_HOLD;
    x_sel        = X_SEL_ZERO;
    pe_issue     = 1'b0;
    pe_mask      = 6'b0;
    out_valid    = 1'b0;
    done         = 1'b0;

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        // Each accepted b word also shifts a zero into x, so x starts cleared.
        if (in_en) begin
          b_shreg_en   = 1'b1;
          b_shreg_ctrl = SHREG_SHIFT1;
          b_sel        = B_SEL_IN;
          x_shreg_en   = 1'b1;
          x_shreg_ctrl = SHREG_SHIFT1;
          x_sel        = X_SEL_ZERO;
          if (load_q == ROW_LAST) begin
            state_d = ST_ISSUE;
            load_d  = '0;
            row_d   = '0;
            iter_d  = '0;
          end else begin
            state_d = ST_LOAD;
            load_d  = load_q + 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        pe_issue = 1'b1;
        pe_mask  = mask_raw;
        wait_d   = '0;
        state_d  = (PE_LAT == 1) ? ST_WRITE : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_WRITE;
        else                     wait_d  = wait_q + 1'b1;
      end
      ST_WRITE: begin
        x_shreg_en   = 1'b1;
        x_shreg_ctrl = SHREG_SHIFT1;
        x_sel        = X_SEL_PE;
        b_shreg_en   = 1'b1;
        b_shreg_ctrl = SHREG_SHIFT1;
        b_sel        = B_SEL_RECIRC;
        if (row_q != ROW_LAST) begin
          row_d   = row_q + 1'b1;
          state_d = ST_ISSUE;
        end else if (iter_q != ITER_LAST) begin
          row_d   = '0;
          iter_d  = (iter_q == 4'hF) ? iter_q : iter_q + 4'd1;
          state_d = ST_ISSUE;
        end else begin
          row_d   = '0;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        out_valid    = 1'b1;
        x_shreg_en   = 1'b1;
        x_shreg_ctrl = SHREG_SHIFT1;
        x_sel        = X_SEL_RECIRC;
        if (row_q == ROW_LAST) begin
          done    = 1'b1;
          row_d   = '0;
          iter_d  = '0;
          state_d = ST_IDLE;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gsim_seq_ctrl.sv
// Three controller configurations share one stimulus; a cycle-count model predicts every output.
// Inputs change #1 after posedge; outputs are compared on the negedge.
module tb_gsim_seq_ctrl;

  localparam int N  = 16;
  localparam int NI = 3;

  localparam int B_IR = 26, B_BEN = 25, B_BSEL = 22, B_XEN = 21, B_PEI = 16;
  localparam int B_OV = 1, B_DN = 0;
  localparam logic [26:0] IDLE_VEC = 27'h4000000;

  logic clk = 1'b0;
  logic rst_n;
  logic in_en;
  logic [26:0] obs [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic       ir, ben, bsel, xen, pei, ov, dn;
    logic [1:0] bc, xc, xs;
    logic [5:0] pm;
    logic [3:0] ri, it;
    gsim_seq_ctrl #(
      .N       (N),
      .NR_ITER ((g == 0) ? 10 : ((g == 1) ? 1 : 2)),
      .PE_LAT  ((g == 0) ? 2  : ((g == 1) ? 1 : 3))
    ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_en        (in_en),
      .in_ready     (ir),
      .b_shreg_en   (ben),
      .b_shreg_ctrl (bc),
      .b_sel        (bsel),
      .x_shreg_en   (xen),
      .x_shreg_ctrl (xc),
      .x_sel        (xs),
      .pe_issue     (pei),
      .pe_mask      (pm),
      .row_idx      (ri),
      .iter_idx     (it),
      .out_valid    (ov),
      .done         (dn)
    );
    assign obs[g] = {ir, ben, bc, bsel, xen, xc, xs, pei, pm, ri, it, ov, dn};
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lat_of(int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 3);
  endfunction

  function automatic int nit_of(int g);
    return (g == 0) ? 10 : ((g == 1) ? 1 : 2);
  endfunction

  function automatic logic [5:0] mask_of(int r);
    logic [5:0] m;
    for (int k = 1; k <= 3; k++) begin
      m[2*k-2] = (r + k <= N - 1);
      m[2*k-1] = (r - k >= 0);
    end
    return m;
  endfunction

  // Model state: phase (0 load/idle, 1 calc, 2 out), words taken, cycles spent in phase.
  int  mode [NI];
  int  loaded [NI];
  int  tph [NI];
  bit  model_ok = 1'b0;

  function automatic logic [26:0] model_exp(int g, logic en);
    logic ir, ben, bsel, xen, pei, ov, dn;
    logic [1:0] bc, xc, xs;
    logic [5:0] pm;
    int ri, it, per, rt, pos;
    ir = 0; ben = 0; bsel = 0; xen = 0; pei = 0; ov = 0; dn = 0;
    bc = 0; xc = 0; xs = 0; pm = 0; ri = 0; it = 0;
    if (mode[g] == 0) begin
      ir = 1;
      if (en) begin
        ben = 1; bc = 2'b01; xen = 1; xc = 2'b01;
      end
    end else if (mode[g] == 1) begin
      per = lat_of(g) + 1;
      rt  = tph[g] / per;
      pos = tph[g] % per;
      ri  = rt % N;
      it  = rt / N;
      if (pos == 0) begin
        pei = 1;
        pm  = mask_of(ri);
      end
      if (pos == lat_of(g)) begin
        ben = 1; bc = 2'b01; bsel = 1; xen = 1; xc = 2'b01; xs = 2'b01;
      end
    end else begin
      ov = 1; xen = 1; xc = 2'b01; xs = 2'b10;
      ri = tph[g];
      it = nit_of(g) - 1;
      dn = (tph[g] == N - 1);
    end
    return {ir, ben, bc, bsel, xen, xc, xs, pei, pm, 4'(ri), 4'(it), ov, dn};
  endfunction

  task automatic model_step(input int g, input logic en);
    if (mode[g] == 0) begin
      if (en) begin
        loaded[g]++;
        if (loaded[g] == N) begin
          mode[g] = 1; tph[g] = 0; loaded[g] = 0;
        end
      end
    end else if (mode[g] == 1) begin
      tph[g]++;
      if (tph[g] == nit_of(g) * N * (lat_of(g) + 1)) begin
        mode[g] = 2; tph[g] = 0;
      end
    end else begin
      tph[g]++;
      if (tph[g] == N) begin
        mode[g] = 0; tph[g] = 0;
      end
    end
  endtask

  // Scenario bookkeeping filled by the monitor.
  bit phase_a = 0, phase_b = 0;
  int a0 = 0;
  int first_issue = -1, issue_cnt = 0, first_ov = -1, done_cyc = -1;
  int fast_ov = -1, slow_ov = -1, bsel0_calc = 0;
  int acc_cnt = 0, acc16 = -1, issue_b = -1;

  initial begin
    logic [26:0] exp_v;
    int rc;
    forever begin
      @(negedge clk);
      if (model_ok) begin
        for (int g = 0; g < NI; g++) begin
          exp_v = model_exp(g, in_en);
          n_chk++;
          if (obs[g] !== exp_v) begin
            n_err++;
            $display("FAIL model_inst%0d cyc=%0d: got %h expected %h", g, cyc, obs[g], exp_v);
          end
        end
      end
      if (phase_a) begin
        rc = cyc - a0;
        if (obs[0][B_PEI] && rc < 512) begin
          if (first_issue < 0) first_issue = rc;
          issue_cnt++;
          if (obs[0][5:2] == 4'd0) begin
            case (obs[0][9:6])
              4'd0:  chk("mask_row0",  int'(obs[0][15:10]), 6'b010101);
              4'd1:  chk("mask_row1",  int'(obs[0][15:10]), 6'b010111);
              4'd2:  chk("mask_row2",  int'(obs[0][15:10]), 6'b011111);
              4'd3:  chk("mask_row3",  int'(obs[0][15:10]), 6'b111111);
              4'd13: chk("mask_row13", int'(obs[0][15:10]), 6'b101111);
              4'd15: chk("mask_row15", int'(obs[0][15:10]), 6'b101010);
              default: ;
            endcase
          end
        end
        if (rc < 16)
          chk("load_word_ctrl", int'({obs[0][B_BEN], obs[0][B_BSEL], obs[0][18:17]}), 4'b1000);
        else if (rc < 512 && obs[0][B_BEN] && !obs[0][B_BSEL])
          bsel0_calc++;
        if (obs[0][B_OV] && first_ov < 0) first_ov = rc;
        if (obs[0][B_DN] && done_cyc < 0) done_cyc = rc;
        if (obs[1][B_OV] && fast_ov < 0) fast_ov = rc;
        if (obs[2][B_OV] && slow_ov < 0) slow_ov = rc;
        if (rc == 512) chk("in_ready_after_done", int'(obs[0][B_IR]), 1);
      end
      if (phase_b) begin
        if (obs[0][B_IR] && in_en) begin
          acc_cnt++;
          if (acc_cnt == 16) acc16 = cyc;
        end
        if (obs[0][B_PEI] && issue_b < 0) issue_b = cyc;
      end
      if (!rst_n) begin
        model_ok = 1'b1;
        for (int g = 0; g < NI; g++) begin
          mode[g] = 0; loaded[g] = 0; tph[g] = 0;
        end
      end else if (model_ok) begin
        for (int g = 0; g < NI; g++) model_step(g, in_en);
      end
      cyc++;
    end
  end

  initial begin
    int k;
    rst_n = 1'b0;
    in_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("idle_outputs", int'(obs[0]), int'(IDLE_VEC));

    // Contiguous load with in_en held high through Calc and Out.
    a0 = cyc;
    phase_a = 1;
    in_en = 1'b1;
    repeat (512) begin
      @(posedge clk);
      #1;
    end
    in_en = 1'b0;
    @(posedge clk);
    #1;
    phase_a = 0;
    chk("first_issue_cycle", first_issue, 16);
    chk("issue_count", issue_cnt, 160);
    chk("first_out_valid", first_ov, 496);
    chk("done_cycle", done_cyc, 511);
    chk("fast_first_out", fast_ov, 48);
    chk("lat3_first_out", slow_ov, 144);
    chk("no_b_in_during_calc", bsel0_calc, 0);

    // Gapped load: in_en on alternate cycles.
    phase_b = 1;
    k = 0;
    while (issue_b < 0 && k < 80) begin
      in_en = (k % 2 == 0);
      @(posedge clk);
      #1;
      k++;
    end
    phase_b = 0;
    chk("gapped_accepts", acc_cnt, 16);
    chk("gapped_issue_delay", issue_b - acc16, 1);

    // Random traffic until Out, then reset in the middle of it.
    k = 0;
    while (!obs[0][B_OV] && k < 3000) begin
      in_en = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      k++;
    end
    chk("reached_out", int'(obs[0][B_OV]), 1);
    repeat (5) begin
      in_en = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    chk("mid_out_before_reset", int'(obs[0][B_OV]), 1);
    rst_n = 1'b0;
    in_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("out_valid_after_reset", int'(obs[0][B_OV]), 0);
    chk("state_after_reset", int'(obs[0]), int'(IDLE_VEC));

    // Long random run with occasional resets.
    repeat (3000) begin
      rst_n = ($urandom_range(0, 599) != 0);
      in_en = rst_n && ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    in_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
